// File: rtl/mux_arbiter.sv
// mux_arbiter
// Packet-level controller for the 2:1 flit mux in the router output stage.
// Grants one input port from its HEAD flit through its TAIL flit (wormhole
// lock), back-pressures the losing port, resolves contention between packets
// round-robin, and force-releases a lock whose packet exceeds MAXLEN flits.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   ivalid_0/1 in   flit valid on port 0 / port 1
//   itype_0/1  in   flit type field on port 0 / port 1
//   ordy       in   downstream accepts a flit this cycle
//   sel        out  one-hot mux select (01 = port 0, 10 = port 1, 00 = none)
//   irdy_0/1   out  upstream ready for port 0 / port 1 (combinational)
//   busy       out  a packet lock is held
//   err_wdog   out  one-cycle pulse when the watchdog forces a release
//   pkt_cnt_0/1 out completed packets per port, wrapping
module mux_arbiter #(
    parameter int unsigned            TYPEW     = 2,
    parameter logic [TYPEW-1:0]       TYPE_NONE = TYPEW'(0),
    parameter logic [TYPEW-1:0]       TYPE_HEAD = TYPEW'(1),
    parameter logic [TYPEW-1:0]       TYPE_DATA = TYPEW'(2),
    parameter logic [TYPEW-1:0]       TYPE_TAIL = TYPEW'(3),
    parameter int unsigned            MAXLEN    = 32,
    parameter int unsigned            CNTW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_0,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             ordy,
    output logic [1:0]       sel,
    output logic             irdy_0,
    output logic             irdy_1,
    output logic             busy,
    output logic             err_wdog,
    output logic [CNTW-1:0]  pkt_cnt_0,
    output logic [CNTW-1:0]  pkt_cnt_1
);

    // Flit count at which a non-TAIL transfer is the MAXLEN-th flit.
    localparam logic [7:0] FCNT_LIMIT = 8'(MAXLEN - 1);

    // Catch illegal configurations at elaboration time.
    if ((MAXLEN < 2) || (MAXLEN > 255)) begin : g_bad_maxlen
        $error("mux_arbiter: MAXLEN must lie within 2..255");
    end
    if ((TYPE_NONE == TYPE_HEAD) || (TYPE_NONE == TYPE_DATA) ||
        (TYPE_NONE == TYPE_TAIL) || (TYPE_HEAD == TYPE_DATA) ||
        (TYPE_HEAD == TYPE_TAIL) || (TYPE_DATA == TYPE_TAIL)) begin : g_bad_types
        $error("mux_arbiter: flit type encodings must be distinct");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            wdog_d;
    logic [1:0]      sel_d;
    logic [CNTW-1:0] cnt0_d, cnt1_d;

    logic            head_0, head_1;
    logic            xfer;
    logic            is_tail;

    // Ready depends only on the lock state and ordy, never on ivalid.
    assign irdy_0 = (state_q == LOCK0) && ordy;
    assign irdy_1 = (state_q == LOCK1) && ordy;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        fcnt_d  = fcnt_q;
        wdog_d  = 1'b0;
        cnt0_d  = pkt_cnt_0;
        cnt1_d  = pkt_cnt_1;
        xfer    = 1'b0;
        is_tail = 1'b0;
        sel_d   = 2'b00;

        head_0 = ivalid_0 && (itype_0 == TYPE_HEAD);
        head_1 = ivalid_1 && (itype_1 == TYPE_HEAD);

        unique case (state_q)
            IDLE: begin
                // Head detection runs regardless of ordy. On a tie the port
                // that was not granted last wins (last_q = 1 favours port 0).
                if (head_0 && (!head_1 || last_q)) begin
                    state_d = LOCK0;
                    last_d  = 1'b0;
                    fcnt_d  = '0;
                end else if (head_1) begin
                    state_d = LOCK1;
                    last_d  = 1'b1;
                    fcnt_d  = '0;
                end
            end
            LOCK0: begin
                xfer    = ivalid_0 && ordy;
                is_tail = (itype_0 == TYPE_TAIL);
            end
            LOCK1: begin
                xfer    = ivalid_1 && ordy;
                is_tail = (itype_1 == TYPE_TAIL);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (xfer) begin
            fcnt_d = fcnt_q + 8'd1;
            if (is_tail || (fcnt_q == FCNT_LIMIT)) begin
                if (is_tail) begin
                    if (state_q == LOCK0) begin
                        cnt0_d = pkt_cnt_0 + CNTW'(1);
                    end else begin
                        cnt1_d = pkt_cnt_1 + CNTW'(1);
                    end
                end else begin
                    wdog_d = 1'b1;
                end
                // A HEAD already waiting on the other port takes over on the
                // same edge, giving a zero-bubble hand-off.
                if ((state_q == LOCK0) && head_1) begin
                    state_d = LOCK1;
                    last_d  = 1'b1;
                    fcnt_d  = '0;
                end else if ((state_q == LOCK1) && head_0) begin
                    state_d = LOCK0;
                    last_d  = 1'b0;
                    fcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        unique case (state_d)
            LOCK0:   sel_d = 2'b01;
            LOCK1:   sel_d = 2'b10;
            default: sel_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            fcnt_q    <= '0;
            sel       <= 2'b00;
            busy      <= 1'b0;
            err_wdog  <= 1'b0;
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            fcnt_q    <= fcnt_d;
            sel       <= sel_d;
            busy      <= (state_d != IDLE);
            err_wdog  <= wdog_d;
            pkt_cnt_0 <= cnt0_d;
            pkt_cnt_1 <= cnt1_d;
        end
    end

endmodule
